hazard_stall_ctrl: RTL

//  Hazard and stall scheduler for the 5-stage pipeline.

---
 rtl/hazard_stall_ctrl.sv | 69 ++++++
 1 files changed

// File: rtl/hazard_stall_ctrl.sv
// hazard_stall_ctrl: data/structural hazard detection, pipeline stall control,
// mult/div busy sequencing and a saturating stall-cycle counter.
module hazard_stall_ctrl #(
   parameter int MULT_CYC = 5,
   parameter int DIV_CYC  = 10,
   parameter int CNT_W    = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [4:0]  D_rs_addr,
   input  logic [4:0]  D_rt_addr,
   input  logic [1:0]  D_rs_tuse,
   input  logic [1:0]  D_rt_tuse,
   input  logic        D_is_md,
   input  logic [4:0]  E_wa,
   input  logic [1:0]  E_tnew,
   input  logic [4:0]  M_wa,
   input  logic [1:0]  M_tnew,
   input  logic        E_md_start,
   input  logic        E_md_is_div,
   output logic        pc_en,
   output logic        fd_en,
   output logic        de_clr,
   output logic        md_busy,
   output logic [31:0] stall_cnt
);
   typedef enum logic {IDLE, BUSY} state_t;
   state_t state, state_nx;
   logic [CNT_W-1:0] cnt, cnt_nx;
   logic rs_stall, rt_stall, md_stall, stall;
   always_comb begin
      rs_stall = (D_rs_addr != 5'd0) &&
                 ((D_rs_addr == E_wa && D_rs_tuse < E_tnew) || (D_rs_addr == M_wa && D_rs_tuse < M_tnew));
      rt_stall = (D_rt_addr != 5'd0) &&
                 ((D_rt_addr == E_wa && D_rt_tuse < E_tnew) || (D_rt_addr == M_wa && D_rt_tuse < M_tnew));
      md_busy  = (state == BUSY);
      md_stall = D_is_md && (md_busy || E_md_start);
      stall    = rs_stall || rt_stall || md_stall;
      pc_en    = !reset && !stall;
      fd_en    = !reset && !stall;
      de_clr   = !reset && stall;
   end
   // A start arriving while BUSY is dropped: the counter is never reloaded mid-operation.
   always_comb begin
      state_nx = state;
      cnt_nx   = cnt;
      if (state == IDLE) begin
         if (E_md_start) begin
            state_nx = BUSY;
            cnt_nx   = E_md_is_div ? CNT_W'(DIV_CYC) : CNT_W'(MULT_CYC);
         end
      end else begin
         state_nx = (cnt == CNT_W'(1)) ? IDLE : BUSY;
         cnt_nx   = cnt - CNT_W'(1);
      end
   end
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         cnt       <= '0;
         stall_cnt <= '0;
      end else begin
         state <= state_nx;
         cnt   <= cnt_nx;
         if (stall && stall_cnt != 32'hFFFF_FFFF)
            stall_cnt <= stall_cnt + 32'd1;
      end
   end
endmodule
